// File: rtl/scene_pkg.sv
// Shared definitions for the scene switcher: scene IDs, FSM encoding and default widths.
package scene_pkg;

   // Scene IDs as used by the game FSM's scene select
   localparam int unsigned MENU_ID      = 0;
   localparam int unsigned BATTLE_ID    = 1;
   localparam int unsigned ENDGAME_ID   = 2;
   localparam int unsigned HOWTOPLAY_ID = 3;

   localparam int unsigned SEL_W_DEF = 2;
   localparam int unsigned RGB_W_DEF = 12;

   // StBlank only becomes reachable when SCENE_SWITCH_BLANK_EN is defined
   typedef enum logic [1:0] {
      StIdle,
      StWaitVs,
      StBlank
   } state_e;

endpackage

// File: rtl/scene_frame_sync.sv
// Frame-boundary detector: rising edge of the active channel's vsync. On a switch the
// history bit is reloaded with the new channel's vs so the switch itself is never an edge.
module scene_frame_sync (
   input  logic i_pclk,
   input  logic i_rst,
   input  logic i_vs,
   input  logic i_reload,
   input  logic i_reload_vs,
   output logic o_boundary
);

   logic vs_q;

   // Track previous vs of the active channel, or adopt the incoming channel's vs on a switch
   always_ff @(posedge i_pclk or posedge i_rst) begin
      if (i_rst) begin
         vs_q <= 1'b0;
      end else if (i_reload) begin
         vs_q <= i_reload_vs;
      end else begin
         vs_q <= i_vs;
      end
   end

   assign o_boundary = i_vs & ~vs_q;

endmodule

// File: rtl/scene_switcher.sv
// Frame-synchronous N-way scene selector for the VGA output stage. Scene changes are
// deferred to the active stream's next vsync rising edge.
// Build option: define SCENE_SWITCH_BLANK_EN to force black RGB for BLANK_FRAMES frames
// after each committed switch.
module scene_switcher
   import scene_pkg::*;
#(
   parameter int unsigned N_SCENES     = 4,
   parameter int unsigned SEL_W        = SEL_W_DEF,
   parameter int unsigned RGB_W        = RGB_W_DEF,
   parameter int unsigned BLANK_FRAMES = 1
) (
   input  logic                      i_pclk,
   input  logic                      i_rst,
   input  logic [SEL_W-1:0]          i_sel,
   input  logic [N_SCENES*RGB_W-1:0] i_rgb,
   input  logic [N_SCENES-1:0]       i_vs,
   input  logic [N_SCENES-1:0]       i_hs,
   output logic [RGB_W-1:0]          o_rgb,
   output logic                      o_vs,
   output logic                      o_hs,
   output logic [SEL_W-1:0]          o_active_sel,
   output logic                      o_busy
);

   localparam int unsigned NSLOT = 1 << SEL_W;
`ifdef SCENE_SWITCH_BLANK_EN
   localparam bit BLANK_EN = 1'b1;
`else
   localparam bit BLANK_EN = 1'b0;
`endif
   localparam bit GO_BLANK = BLANK_EN && (BLANK_FRAMES != 0);

   state_e           state_q;
   logic [SEL_W-1:0] active_q;
   logic [SEL_W-1:0] pending_q;
   logic             run_q;
   logic [RGB_W-1:0] rgb_q;
   logic             vs_out_q;
   logic             hs_q;
   logic             busy_q;
`ifdef SCENE_SWITCH_BLANK_EN
   logic [7:0]       cnt_q;
`endif

   // Pad the streams out to every encodable ID; unused slots read as zero
   logic [RGB_W-1:0] rgb_arr [NSLOT];
   logic [NSLOT-1:0] vs_arr;
   logic [NSLOT-1:0] hs_arr;

   for (genvar k = 0; k < NSLOT; k++) begin : g_slot
      if (k < N_SCENES) begin : g_used
         assign rgb_arr[k] = i_rgb[k*RGB_W +: RGB_W];
         assign vs_arr[k]  = i_vs[k];
         assign hs_arr[k]  = i_hs[k];
      end else begin : g_unused
         assign rgb_arr[k] = '0;
         assign vs_arr[k]  = 1'b0;
         assign hs_arr[k]  = 1'b0;
      end
   end

   logic sel_valid;
   logic request;
   logic boundary;
   logic commit;

   assign sel_valid = 32'(i_sel) < N_SCENES;
   // run_q masks the first edge after reset release
   assign request   = run_q && sel_valid && (i_sel != active_q);
   assign commit    = (state_q == StWaitVs) && boundary;

   scene_frame_sync u_frame_sync (
      .i_pclk      (i_pclk),
      .i_rst       (i_rst),
      .i_vs        (vs_arr[active_q]),
      .i_reload    (commit),
      .i_reload_vs (vs_arr[pending_q]),
      .o_boundary  (boundary)
   );

   // Switch FSM with registered pixel/sync outputs taken from the current active stream
   always_ff @(posedge i_pclk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= StIdle;
         active_q  <= SEL_W'(MENU_ID);
         pending_q <= '0;
         run_q     <= 1'b0;
         rgb_q     <= '0;
         vs_out_q  <= 1'b0;
         hs_q      <= 1'b0;
         busy_q    <= 1'b0;
`ifdef SCENE_SWITCH_BLANK_EN
         cnt_q     <= '0;
`endif
      end else begin
         run_q    <= 1'b1;
         rgb_q    <= rgb_arr[active_q];
         vs_out_q <= vs_arr[active_q];
         hs_q     <= hs_arr[active_q];
         unique case (state_q)
            StIdle: begin
               if (request) begin
                  pending_q <= i_sel;
                  state_q   <= StWaitVs;
                  busy_q    <= 1'b1;
               end
            end
            StWaitVs: begin
               // A boundary wins over a same-cycle select change
               if (boundary) begin
                  active_q <= pending_q;
                  if (GO_BLANK) begin
                     state_q <= StBlank;
                     rgb_q   <= '0;
`ifdef SCENE_SWITCH_BLANK_EN
                     cnt_q   <= 8'(BLANK_FRAMES);
`endif
                  end else begin
                     state_q <= StIdle;
                     busy_q  <= 1'b0;
                  end
               end else if (i_sel == active_q) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else if (sel_valid) begin
                  pending_q <= i_sel;
               end
            end
`ifdef SCENE_SWITCH_BLANK_EN
            StBlank: begin
               if (boundary && (cnt_q == 8'd1)) begin
                  cnt_q   <= '0;
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else begin
                  if (boundary) begin
                     cnt_q <= cnt_q - 8'd1;
                  end
                  rgb_q <= '0;
               end
            end
`endif
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign o_rgb        = rgb_q;
   assign o_vs         = vs_out_q;
   assign o_hs         = hs_q;
   assign o_active_sel = active_q;
   assign o_busy       = busy_q;

endmodule

// File: tb/tb_scene_switcher.sv
// Directed bench for scene_switcher: expected outputs are queued as each step is driven
// and compared once the clock edge has produced them.
module tb_scene_switcher;

`ifdef SCENE_SWITCH_BLANK_EN
   localparam bit B = 1'b1;
`else
   localparam bit B = 1'b0;
`endif

   logic        i_pclk = 1'b0;
   logic        i_rst;
   logic [1:0]  i_sel;
   logic [47:0] i_rgb;
   logic [3:0]  i_vs;
   logic [3:0]  i_hs;
   logic [11:0] o_rgb;
   logic        o_vs;
   logic        o_hs;
   logic [1:0]  o_active_sel;
   logic        o_busy;

   logic [1:0]  s3_sel;
   logic [35:0] s3_rgb;
   logic [2:0]  s3_vs;
   logic [2:0]  s3_hs;
   logic [11:0] s3_o_rgb;
   logic        s3_o_vs;
   logic        s3_o_hs;
   logic [1:0]  s3_o_active_sel;
   logic        s3_o_busy;

   always #5 i_pclk = ~i_pclk;

   scene_switcher #(
      .N_SCENES     (4),
      .SEL_W        (2),
      .RGB_W        (12),
      .BLANK_FRAMES (1)
   ) dut (
      .i_pclk       (i_pclk),
      .i_rst        (i_rst),
      .i_sel        (i_sel),
      .i_rgb        (i_rgb),
      .i_vs         (i_vs),
      .i_hs         (i_hs),
      .o_rgb        (o_rgb),
      .o_vs         (o_vs),
      .o_hs         (o_hs),
      .o_active_sel (o_active_sel),
      .o_busy       (o_busy)
   );

   scene_switcher #(
      .N_SCENES     (3),
      .SEL_W        (2),
      .RGB_W        (12),
      .BLANK_FRAMES (1)
   ) dut3 (
      .i_pclk       (i_pclk),
      .i_rst        (i_rst),
      .i_sel        (s3_sel),
      .i_rgb        (s3_rgb),
      .i_vs         (s3_vs),
      .i_hs         (s3_hs),
      .o_rgb        (s3_o_rgb),
      .o_vs         (s3_o_vs),
      .o_hs         (s3_o_hs),
      .o_active_sel (s3_o_active_sel),
      .o_busy       (s3_o_busy)
   );

   typedef struct {
      string       tag;
      logic [11:0] rgb;
      logic        vs;
      logic        hs;
      logic [1:0]  sel;
      logic        busy;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [11:0] rgb_tbl [4] = '{12'hABC, 12'h111, 12'h222, 12'h333};
   logic [3:0]  hs_pat = 4'b0110;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Drive one cycle of stimulus; src is the scene whose data should appear, blank forces rgb=0
   task automatic step(input string tag, input logic [3:0] vs, input logic [1:0] sel,
                       input int src, input bit blank, input logic [1:0] exp_sel,
                       input bit exp_busy);
      exp_t e;
      i_vs  = vs;
      i_sel = sel;
      e.tag  = tag;
      e.rgb  = blank ? 12'h000 : rgb_tbl[src];
      e.vs   = vs[src];
      e.hs   = hs_pat[src];
      e.sel  = exp_sel;
      e.busy = exp_busy;
      sb.push_back(e);
      @(posedge i_pclk);
      #1;
      e = sb.pop_front();
      check({e.tag, ".rgb"},  32'(o_rgb),        32'(e.rgb));
      check({e.tag, ".vs"},   32'(o_vs),         32'(e.vs));
      check({e.tag, ".hs"},   32'(o_hs),         32'(e.hs));
      check({e.tag, ".sel"},  32'(o_active_sel), 32'(e.sel));
      check({e.tag, ".busy"}, 32'(o_busy),       32'(e.busy));
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".rgb"},  32'(o_rgb),        32'd0);
      check({tag, ".vs"},   32'(o_vs),         32'd0);
      check({tag, ".hs"},   32'(o_hs),         32'd0);
      check({tag, ".sel"},  32'(o_active_sel), 32'd0);
      check({tag, ".busy"}, 32'(o_busy),       32'd0);
   endtask

   task automatic tick3(input logic [1:0] sel, input logic [2:0] vs);
      s3_sel = sel;
      s3_vs  = vs;
      @(posedge i_pclk);
      #1;
   endtask

   initial begin
      i_rst  = 1'b1;
      i_sel  = 2'd0;
      i_vs   = 4'b0000;
      i_hs   = hs_pat;
      i_rgb  = {12'h333, 12'h222, 12'h111, 12'hABC};
      s3_sel = 2'd0;
      s3_vs  = 3'b000;
      s3_hs  = 3'b000;
      s3_rgb = {12'h777, 12'h666, 12'h555};
      repeat (2) @(posedge i_pclk);
      #1;
      check_zero("reset");
      i_rst = 1'b0;

      // Request coinciding with reset release is ignored
      step("rel_req", 4'b0000, 2'd1, 0, 1'b0, 2'd0, 1'b0);
      step("idle0",   4'b0000, 2'd0, 0, 1'b0, 2'd0, 1'b0);

      // Switch 0 -> 1, deferred to scene 0's vs rising edge
      step("req1", 4'b0000, 2'd1, 0, 1'b0, 2'd0, 1'b1);
      for (int i = 0; i < 500; i++) step("wait_vs0", 4'b0000, 2'd1, 0, 1'b0, 2'd0, 1'b1);
      step("commit1", 4'b0001, 2'd1, 0, B, 2'd1, B);
      for (int i = 0; i < 3; i++) step("blank1", 4'b0000, 2'd1, 1, B, 2'd1, B);
      step("exit1",  4'b0010, 2'd1, 1, 1'b0, 2'd1, 1'b0);
      step("idle1",  4'b0000, 2'd1, 1, 1'b0, 2'd1, 1'b0);

      // Retarget 2 -> 3 in WAIT_VS; new channel's vs already high at commit
      step("sel2",    4'b0000, 2'd2, 1, 1'b0, 2'd1, 1'b1);
      step("sel3",    4'b0000, 2'd3, 1, 1'b0, 2'd1, 1'b1);
      step("commit3", 4'b1010, 2'd3, 1, B,    2'd3, B);
      step("hi3",     4'b1000, 2'd3, 3, B,    2'd3, B);
      step("lo3",     4'b0000, 2'd3, 3, B,    2'd3, B);
      step("exit3",   4'b1000, 2'd3, 3, 1'b0, 2'd3, 1'b0);
      step("idle3",   4'b0000, 2'd3, 3, 1'b0, 2'd3, 1'b0);

      // Cancel by returning to the active scene before the boundary
      step("req2",   4'b0000, 2'd2, 3, 1'b0, 2'd3, 1'b1);
      step("cancel", 4'b0000, 2'd3, 3, 1'b0, 2'd3, 1'b0);
      step("nosw",   4'b1000, 2'd3, 3, 1'b0, 2'd3, 1'b0);
      step("nosw2",  4'b0000, 2'd3, 3, 1'b0, 2'd3, 1'b0);

      // Boundary and select change together commit to the latched pending scene
      step("req2b",     4'b0000, 2'd2, 3, 1'b0, 2'd3, 1'b1);
      step("simul",     4'b1000, 2'd1, 3, B,    2'd2, B);
      step("fast_edge", 4'b1100, 2'd1, 2, 1'b0, 2'd2, !B);
      step("req_after", 4'b0100, 2'd1, 2, 1'b0, 2'd2, 1'b1);
      step("wait2",     4'b0000, 2'd1, 2, 1'b0, 2'd2, 1'b1);
      step("commit1b",  4'b0100, 2'd1, 2, B,    2'd1, B);
      step("blk1",      4'b0000, 2'd1, 1, B,    2'd1, B);

      // Asynchronous reset mid-switch
      #2;
      i_rst = 1'b1;
      #1;
      check_zero("async_rst");
      @(posedge i_pclk);
      #1;
      i_rst = 1'b0;
      step("post_rst",  4'b0000, 2'd0, 0, 1'b0, 2'd0, 1'b0);
      step("post_rst2", 4'b0000, 2'd0, 0, 1'b0, 2'd0, 1'b0);

      // Out-of-range select on a 3-scene instance
      tick3(2'd3, 3'b000);
      check("n3_inv.sel",  32'(s3_o_active_sel), 32'd0);
      check("n3_inv.busy", 32'(s3_o_busy),       32'd0);
      tick3(2'd3, 3'b000);
      check("n3_inv2.busy", 32'(s3_o_busy), 32'd0);
      tick3(2'd2, 3'b000);
      check("n3_req.busy", 32'(s3_o_busy), 32'd1);
      tick3(2'd3, 3'b000);
      check("n3_wait_inv.sel",  32'(s3_o_active_sel), 32'd0);
      check("n3_wait_inv.busy", 32'(s3_o_busy),       32'd1);
      tick3(2'd3, 3'b001);
      check("n3_commit.sel",  32'(s3_o_active_sel), 32'd2);
      check("n3_commit.busy", 32'(s3_o_busy),       32'(B));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/scene_switcher.md
Name: scene_switcher

Overview:
- Parametrised, frame-synchronous successor to the fixed 4-way scene multiplexer. Selects one of N_SCENES video streams (rgb/vs/hs) for the VGA output stage.
- Scene changes are deferred to the active stream's frame boundary, so a switch never tears a frame or truncates a sync pulse.
- Optionally blanks RGB for a programmable number of frames after a switch.
- Sits between the per-scene renderers and the VGA output register stage; driven by the game FSM's scene select.

Parameters:
- N_SCENES, 4, number of input streams (2..2**SEL_W).
- SEL_W, 2, width of the select and scene-ID fields.
- RGB_W, 12, pixel colour width per stream.
- BLANK_FRAMES, 1, frames of forced-black output after a committed switch (0..255). Used only with SCENE_SWITCH_BLANK_EN.

Ports:
- i_pclk  in  1  pixel clock; the only clock.
- i_rst  in  1  reset, asynchronous and active-high.
- i_sel  in  SEL_W  requested scene ID; may change on any cycle.
- i_rgb  in  N_SCENES*RGB_W  flattened pixel data; scene k occupies bits [k*RGB_W +: RGB_W].
- i_vs  in  N_SCENES  vsync per scene, active-high.
- i_hs  in  N_SCENES  hsync per scene.
- o_rgb  out  RGB_W  registered pixel output.
- o_vs  out  1  registered vsync.
- o_hs  out  1  registered hsync.
- o_active_sel  out  SEL_W  scene currently driving the outputs.
- o_busy  out  1  high while a switch is pending or blanking.

Behaviour:
- Reset (async assert, synchronous release on i_pclk):
  - o_rgb=0, o_vs=0, o_hs=0, o_active_sel=0, o_busy=0.
  - State IDLE; pending=0; frame counter=0; vs edge register=0.
- Datapath:
  - o_rgb/o_vs/o_hs are registered copies of stream o_active_sel, giving 1-cycle latency, same as the previous mux.
  - In BLANK, o_rgb=0 while syncs still pass through unchanged.
- Frame boundary: a rising edge of i_vs[active], detected against a 1-cycle delayed copy of that same bit.
  - On every change of the active index, the delayed copy is reloaded with the new channel's current vs, so the switch itself can never produce a false edge.
- Request: i_sel != o_active_sel and i_sel < N_SCENES. An i_sel >= N_SCENES is ignored in every state.
- FSM:
  - IDLE: o_busy=0. On a request, latch pending=i_sel and go to WAIT_VS (o_busy=1 from the next cycle).
  - WAIT_VS: pending tracks each new valid i_sel (last value wins).
    - If i_sel returns to o_active_sel, return to IDLE with no switch.
    - On a frame boundary: o_active_sel<=pending in the same cycle as the edge; load counter=BLANK_FRAMES; go to BLANK.
    - If BLANK_FRAMES=0, go to IDLE instead of BLANK.
  - BLANK: the counter decrements on each frame boundary of the new active channel. When it reaches 0 on an edge, go to IDLE.
    - i_sel changes are held off and evaluated as a fresh request in the IDLE cycle that follows.
- Simultaneous events:
  - A boundary and an i_sel change in the same WAIT_VS cycle: the switch commits to the previously latched pending. The new i_sel is evaluated afterwards.
  - A request in the same cycle as reset release is ignored.
- Reset mid-switch: the block immediately returns to scene 0 and IDLE. Any pending request is discarded.
- A scene whose vs never toggles holds the block in WAIT_VS indefinitely. This is documented behaviour; there is no timeout.

Optional Feature:
- SCENE_SWITCH_BLANK_EN defined: the BLANK state and counter are present and behave as above.
- Not defined: there is no BLANK state or counter. WAIT_VS commits and returns directly to IDLE, and BLANK_FRAMES is ignored. o_rgb is never forced to 0 except at reset.

Decomposition:
- Package scene_pkg holds:
  - scene ID constants MENU_ID=0, BATTLE_ID=1, ENDGAME_ID=2, HOWTOPLAY_ID=3;
  - the FSM state encoding IDLE/WAIT_VS/BLANK;
  - the default SEL_W and RGB_W.
- One sub-module, scene_frame_sync, is natural: the vs edge detector with a reload-on-switch input.

Test Plan:
- Reset, then drive scene 0 rgb=12'hABC with i_sel=0 -> o_rgb=12'hABC one cycle later; o_active_sel=0; o_busy=0.
- i_sel=1 mid-frame, scene 0 vs rises 500 cycles later -> o_active_sel=1 exactly on the edge cycle, o_busy high throughout. With BLANK on and BLANK_FRAMES=1, o_rgb=0 until the next rising edge of i_vs[1], then scene 1 data.
- i_sel 0->2->3 during WAIT_VS -> the commit goes to 3. Setting i_sel back to 0 before the edge -> no switch, IDLE, o_busy=0.
- i_sel=3 with N_SCENES=3 -> ignored; state stays IDLE and o_active_sel is unchanged.
- Switch to scene 1 while i_vs[1] is already high -> no spurious boundary on the switch cycle; blanking counts only genuine later rising edges.
- Assert i_rst during BLANK -> outputs go to 0 asynchronously. After release: o_active_sel=0, IDLE, o_busy=0.
